pa_idu_gpr_wb_ctrl: RTL and testbench
=====================================

Name: pa_idu_gpr_wb_ctrl

Overview:
- Write-back port controller directly upstream of the 32 per-GPR register slices in the IDU.
- Collects results from the EX pipe (port 0), the LSU (port 1) and the shared long-latency port 2 (DIV and MUL).
- Decodes each destination index into one-hot per-register write enables and drives the three write-data buses.
- Arbitrates DIV/MUL contention on port 2 with a one-entry hold buffer and a valid/ready handshake.

Parameters:
- NUM_GPR, 32, number of architectural GPRs; width of every one-hot enable vector.
- DW, 32, data width of every write-data bus.

Ports:
- reg_cpuclk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- ex_wb_vld  in  1  EX result valid.
- ex_wb_rd  in  5  EX destination index.
- ex_wb_data  in  DW  EX result.
- lsu_wb_vld  in  1  load data valid.
- lsu_wb_rd  in  5  load destination index.
- lsu_wb_data  in  DW  load data.
- div_wb_vld  in  1  divider result valid; held until div_wb_rdy.
- div_wb_rd  in  5  divider destination index.
- div_wb_data  in  DW  divider result.
- div_wb_rdy  out  1  divider result accepted this cycle.
- mul_wb_vld  in  1  multi-cycle multiplier result valid; held until mul_wb_rdy.
- mul_wb_rd  in  5  multiplier destination index.
- mul_wb_data  in  DW  multiplier result.
- mul_wb_rdy  out  1  multiplier result accepted this cycle.
- wb_write_en0  out  NUM_GPR  one-hot port-0 enable to the register slices.
- wb_write_en1  out  NUM_GPR  one-hot port-1 enable to the register slices.
- wb_write_en2  out  NUM_GPR  one-hot port-2 enable to the register slices.
- write_data0  out  DW  port-0 data.
- write_data1  out  DW  port-1 data.
- write_data2  out  DW  port-2 data.
- wb_p2_is_div  out  1  port-2 write this cycle comes from DIV; the slice state machines use it to clear DIV-busy.
- wb_hold_vld  out  1  hold buffer occupied.

Behaviour:
- Reset (cpurst_b=0): FSM enters IDLE and the hold buffer is invalidated. All enable vectors are 0, both rdy outputs are 0, wb_p2_is_div=0 and wb_hold_vld=0. Data buses are don't-care.
- Port 0 (combinational, zero latency): wb_write_en0[i] = ex_wb_vld & (ex_wb_rd==i) & (i!=0). write_data0 = ex_wb_data.
- Port 1 (combinational, zero latency): same decode using the lsu_* inputs.
- x0: bit 0 of every enable vector is constantly 0. A valid request to rd=0 is still handshaken, with no write.
- Port-2 FSM, state IDLE:
  - Only DIV valid: port 2 driven from the div_* inputs; div_wb_rdy=1, wb_p2_is_div=1.
  - Only MUL valid: port 2 driven from the mul_* inputs; mul_wb_rdy=1, wb_p2_is_div=0.
  - Both valid: DIV drives port 2 and div_wb_rdy=1. MUL is also accepted (mul_wb_rdy=1) and its rd/data/src are captured into the hold buffer at the clock edge. Next state is HOLD.
  - Neither valid: port 2 is idle and the FSM stays in IDLE.
- Port-2 FSM, state HOLD:
  - Port 2 is driven from the hold buffer; wb_p2_is_div reflects the buffered source.
  - div_wb_rdy=0 and mul_wb_rdy=0 (new requests wait).
  - Buffer is invalidated at the edge; next state is IDLE.
  - Latency for a collided MUL result: 1 cycle.
- rdy is asserted only while the corresponding vld is high. The rdy outputs are combinational from vld and state; no vld to rdy loop exists.
- Same rd on several ports in one cycle: all enables are driven; slice priority (port 1 > port 2 > port 0) resolves it. No extra logic here.
- The hold buffer is 1 entry. Overflow is impossible because rdy is deasserted in HOLD.
- Reset mid-HOLD: the buffered MUL result is discarded. Upstream units are reset by the same cpurst_b.
- Flush has no effect. Every result reaching this block belongs to a committed or uncancellable instruction.
- Illegal FSM encoding: returns to IDLE and the buffer is invalidated.

Test Plan:
1. Reset release with all vld=0 -> all three enable vectors 0x00000000, div/mul_wb_rdy=0, wb_hold_vld=0.
2. ex_wb_vld=1, rd=5, data=0x1234_5678, plus lsu_wb_vld=1, rd=31, data=0xDEAD_BEEF in the same cycle -> wb_write_en0=0x00000020, wb_write_en1=0x80000000, both data buses pass through the same cycle.
3. div_wb_vld=1, rd=3, data=0xA, together with mul_wb_vld=1, rd=7, data=0xB ->
   - Cycle 0: en2=0x00000008, data2=0xA, wb_p2_is_div=1, both rdy=1.
   - Cycle 1: en2=0x00000080, data2=0xB, wb_p2_is_div=0, wb_hold_vld=1.
   - Cycle 2: IDLE.
4. During HOLD, a new div_wb_vld=1, rd=9 -> div_wb_rdy=0 in that cycle; next cycle en2=0x00000200, div_wb_rdy=1.
5. ex_wb_vld=1, rd=0 and div_wb_vld=1, rd=0 -> all enable vectors 0, div_wb_rdy=1.
6. Enter HOLD, then assert cpurst_b=0 mid-cycle -> wb_hold_vld drops immediately; after release, en2=0 and the FSM is in IDLE.

Source files
------------

// File: rtl/pa_idu_gpr_wb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pa_idu_gpr_wb_ctrl : GPR write-back port decode and DIV/MUL port-2 arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module pa_idu_gpr_wb_ctrl #(
  parameter int NUM_GPR = 32,
  parameter int DW      = 32
) (
  input  logic               reg_cpuclk,
  input  logic               cpurst_b,
  input  logic               ex_wb_vld,
  input  logic [4:0]         ex_wb_rd,
  input  logic [DW-1:0]      ex_wb_data,
  input  logic               lsu_wb_vld,
  input  logic [4:0]         lsu_wb_rd,
  input  logic [DW-1:0]      lsu_wb_data,
  input  logic               div_wb_vld,
  input  logic [4:0]         div_wb_rd,
  input  logic [DW-1:0]      div_wb_data,
  output logic               div_wb_rdy,
  input  logic               mul_wb_vld,
  input  logic [4:0]         mul_wb_rd,
  input  logic [DW-1:0]      mul_wb_data,
  output logic               mul_wb_rdy,
  output logic [NUM_GPR-1:0] wb_write_en0,
  output logic [NUM_GPR-1:0] wb_write_en1,
  output logic [NUM_GPR-1:0] wb_write_en2,
  output logic [DW-1:0]      write_data0,
  output logic [DW-1:0]      write_data1,
  output logic [DW-1:0]      write_data2,
  output logic               wb_p2_is_div,
  output logic               wb_hold_vld
);

  // One-hot state encoding so that any corrupted value lands in the default arm.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t          r_state;
  logic            r_hold_vld;
  logic [4:0]      r_hold_rd;
  logic [DW-1:0]   r_hold_data;
  logic            r_hold_is_div;

  logic            w_p2_vld;
  logic [4:0]      w_p2_rd;
  logic [DW-1:0]   w_p2_data;
  logic            w_p2_is_div;
  logic            w_div_rdy;
  logic            w_mul_rdy;

  // Port-2 source selection; rdy depends only on vld and state.
  always_comb begin
    w_p2_vld    = 1'b0;
    w_p2_rd     = 5'd0;
    w_p2_data   = '0;
    w_p2_is_div = 1'b0;
    w_div_rdy   = 1'b0;
    w_mul_rdy   = 1'b0;
    case (r_state)
      IDLE: begin
        if (div_wb_vld) begin
          w_p2_vld    = 1'b1;
          w_p2_rd     = div_wb_rd;
          w_p2_data   = div_wb_data;
          w_p2_is_div = 1'b1;
          w_div_rdy   = 1'b1;
          w_mul_rdy   = mul_wb_vld;
        end else if (mul_wb_vld) begin
          w_p2_vld    = 1'b1;
          w_p2_rd     = mul_wb_rd;
          w_p2_data   = mul_wb_data;
          w_mul_rdy   = 1'b1;
        end
      end
      HOLD: begin
        w_p2_vld    = r_hold_vld;
        w_p2_rd     = r_hold_rd;
        w_p2_data   = r_hold_data;
        w_p2_is_div = r_hold_vld & r_hold_is_div;
      end
      default: begin
        w_p2_vld = 1'b0;
      end
    endcase
  end

  always_ff @(posedge reg_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state       <= IDLE;
      r_hold_vld    <= 1'b0;
      r_hold_rd     <= 5'd0;
      r_hold_data   <= '0;
      r_hold_is_div <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A colliding MUL result is accepted now and replayed next cycle.
          if (div_wb_vld && mul_wb_vld) begin
            r_state       <= HOLD;
            r_hold_vld    <= 1'b1;
            r_hold_rd     <= mul_wb_rd;
            r_hold_data   <= mul_wb_data;
            r_hold_is_div <= 1'b0;
          end
        end
        HOLD: begin
          r_state    <= IDLE;
          r_hold_vld <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_hold_vld <= 1'b0;
        end
      endcase
    end
  end

  // x0 is hardwired: bit 0 of every enable vector stays low.
  assign wb_write_en0[0] = 1'b0;
  assign wb_write_en1[0] = 1'b0;
  assign wb_write_en2[0] = 1'b0;

  for (genvar i = 1; i < NUM_GPR; i++) begin : g_dec
    assign wb_write_en0[i] = ex_wb_vld  & (ex_wb_rd  == 5'(i));
    assign wb_write_en1[i] = lsu_wb_vld & (lsu_wb_rd == 5'(i));
    assign wb_write_en2[i] = w_p2_vld   & (w_p2_rd   == 5'(i));
  end

  assign write_data0  = ex_wb_data;
  assign write_data1  = lsu_wb_data;
  assign write_data2  = w_p2_data;
  assign div_wb_rdy   = w_div_rdy;
  assign mul_wb_rdy   = w_mul_rdy;
  assign wb_p2_is_div = w_p2_is_div;
  assign wb_hold_vld  = r_hold_vld;

endmodule
`default_nettype wire

// File: tb/tb_pa_idu_gpr_wb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pa_idu_gpr_wb_ctrl : directed and randomized checks of the write-back controller
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pa_idu_gpr_wb_ctrl;
  localparam int NUM_GPR = 32;
  localparam int DW      = 32;

  logic               reg_cpuclk = 1'b0;
  logic               cpurst_b;
  logic               ex_wb_vld, lsu_wb_vld, div_wb_vld, mul_wb_vld;
  logic [4:0]         ex_wb_rd, lsu_wb_rd, div_wb_rd, mul_wb_rd;
  logic [DW-1:0]      ex_wb_data, lsu_wb_data, div_wb_data, mul_wb_data;
  logic               div_wb_rdy, mul_wb_rdy, wb_p2_is_div, wb_hold_vld;
  logic [NUM_GPR-1:0] wb_write_en0, wb_write_en1, wb_write_en2;
  logic [DW-1:0]      write_data0, write_data1, write_data2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 reg_cpuclk = ~reg_cpuclk;

  pa_idu_gpr_wb_ctrl #(.NUM_GPR(NUM_GPR), .DW(DW)) dut (
    .reg_cpuclk(reg_cpuclk), .cpurst_b(cpurst_b),
    .ex_wb_vld(ex_wb_vld), .ex_wb_rd(ex_wb_rd), .ex_wb_data(ex_wb_data),
    .lsu_wb_vld(lsu_wb_vld), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .div_wb_vld(div_wb_vld), .div_wb_rd(div_wb_rd), .div_wb_data(div_wb_data),
    .div_wb_rdy(div_wb_rdy),
    .mul_wb_vld(mul_wb_vld), .mul_wb_rd(mul_wb_rd), .mul_wb_data(mul_wb_data),
    .mul_wb_rdy(mul_wb_rdy),
    .wb_write_en0(wb_write_en0), .wb_write_en1(wb_write_en1), .wb_write_en2(wb_write_en2),
    .write_data0(write_data0), .write_data1(write_data1), .write_data2(write_data2),
    .wb_p2_is_div(wb_p2_is_div), .wb_hold_vld(wb_hold_vld)
  );

  // Reference decode: a write to register rd, never to x0.
  function automatic logic [NUM_GPR-1:0] onehot(input logic vld, input logic [4:0] rd);
    return (vld && rd != 5'd0) ? (NUM_GPR'(1) << rd) : '0;
  endfunction

  task automatic idle_inputs();
    ex_wb_vld = 0; lsu_wb_vld = 0; div_wb_vld = 0; mul_wb_vld = 0;
    ex_wb_rd = 0; lsu_wb_rd = 0; div_wb_rd = 0; mul_wb_rd = 0;
    ex_wb_data = 0; lsu_wb_data = 0; div_wb_data = 0; mul_wb_data = 0;
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0;
    idle_inputs();
    repeat (2) @(negedge reg_cpuclk);
    #1;
    n_chk++; if ({wb_write_en0, wb_write_en1, wb_write_en2} !== '0) begin n_fail++;
      $display("FAIL reset_en: got %h %h %h want all 0", wb_write_en0, wb_write_en1, wb_write_en2); end
    n_chk++; if ({div_wb_rdy, mul_wb_rdy, wb_p2_is_div, wb_hold_vld} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctl: got rdy=%b%b is_div=%b hold=%b want 0", div_wb_rdy, mul_wb_rdy, wb_p2_is_div, wb_hold_vld); end
    @(negedge reg_cpuclk);
    cpurst_b = 1'b1;
    @(negedge reg_cpuclk);
    #1;
    n_chk++; if ({wb_write_en2, wb_hold_vld, div_wb_rdy, mul_wb_rdy} !== '0) begin n_fail++;
      $display("FAIL post_reset: got en2=%h hold=%b rdy=%b%b want 0", wb_write_en2, wb_hold_vld, div_wb_rdy, mul_wb_rdy); end
  endtask

  task automatic test_ports01();
    @(negedge reg_cpuclk);
    ex_wb_vld = 1; ex_wb_rd = 5; ex_wb_data = 32'h1234_5678;
    lsu_wb_vld = 1; lsu_wb_rd = 31; lsu_wb_data = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (wb_write_en0 !== 32'h0000_0020) begin n_fail++;
      $display("FAIL p0_en: got %h want 00000020", wb_write_en0); end
    n_chk++; if (wb_write_en1 !== 32'h8000_0000) begin n_fail++;
      $display("FAIL p1_en: got %h want 80000000", wb_write_en1); end
    n_chk++; if (write_data0 !== 32'h1234_5678 || write_data1 !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL p01_data: got %h %h want 12345678 deadbeef", write_data0, write_data1); end
    idle_inputs();
  endtask

  task automatic test_collision();
    @(negedge reg_cpuclk);
    div_wb_vld = 1; div_wb_rd = 3; div_wb_data = 32'hA;
    mul_wb_vld = 1; mul_wb_rd = 7; mul_wb_data = 32'hB;
    #1;
    n_chk++; if (wb_write_en2 !== 32'h8 || write_data2 !== 32'hA || wb_p2_is_div !== 1'b1) begin n_fail++;
      $display("FAIL coll_c0: got en2=%h d2=%h is_div=%b want 8 a 1", wb_write_en2, write_data2, wb_p2_is_div); end
    n_chk++; if (div_wb_rdy !== 1'b1 || mul_wb_rdy !== 1'b1) begin n_fail++;
      $display("FAIL coll_rdy: got %b%b want 11", div_wb_rdy, mul_wb_rdy); end
    @(negedge reg_cpuclk);
    mul_wb_vld = 0;
    div_wb_rd = 9; div_wb_data = 32'hC;
    #1;
    n_chk++; if (wb_write_en2 !== 32'h80 || write_data2 !== 32'hB || wb_p2_is_div !== 1'b0 || wb_hold_vld !== 1'b1) begin n_fail++;
      $display("FAIL coll_c1: got en2=%h d2=%h is_div=%b hold=%b want 80 b 0 1", wb_write_en2, write_data2, wb_p2_is_div, wb_hold_vld); end
    n_chk++; if (div_wb_rdy !== 1'b0 || mul_wb_rdy !== 1'b0) begin n_fail++;
      $display("FAIL hold_rdy: got %b%b want 00", div_wb_rdy, mul_wb_rdy); end
    @(negedge reg_cpuclk);
    #1;
    n_chk++; if (wb_write_en2 !== 32'h200 || div_wb_rdy !== 1'b1 || wb_p2_is_div !== 1'b1 || wb_hold_vld !== 1'b0 || write_data2 !== 32'hC) begin n_fail++;
      $display("FAIL coll_c2: got en2=%h rdy=%b is_div=%b hold=%b d2=%h want 200 1 1 0 c", wb_write_en2, div_wb_rdy, wb_p2_is_div, wb_hold_vld, write_data2); end
    idle_inputs();
  endtask

  task automatic test_x0();
    @(negedge reg_cpuclk);
    ex_wb_vld = 1; ex_wb_rd = 0; ex_wb_data = 32'h5555;
    div_wb_vld = 1; div_wb_rd = 0; div_wb_data = 32'h6666;
    #1;
    n_chk++; if ({wb_write_en0, wb_write_en1, wb_write_en2} !== '0) begin n_fail++;
      $display("FAIL x0_en: got %h %h %h want all 0", wb_write_en0, wb_write_en1, wb_write_en2); end
    n_chk++; if (div_wb_rdy !== 1'b1) begin n_fail++;
      $display("FAIL x0_rdy: got %b want 1", div_wb_rdy); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_hold();
    @(negedge reg_cpuclk);
    div_wb_vld = 1; div_wb_rd = 2; div_wb_data = 32'h1;
    mul_wb_vld = 1; mul_wb_rd = 6; mul_wb_data = 32'h2;
    @(negedge reg_cpuclk);
    idle_inputs();
    #1;
    n_chk++; if (wb_hold_vld !== 1'b1) begin n_fail++;
      $display("FAIL mid_hold_pre: got hold=%b want 1", wb_hold_vld); end
    #2 cpurst_b = 1'b0;
    #1;
    n_chk++; if (wb_hold_vld !== 1'b0 || wb_write_en2 !== '0) begin n_fail++;
      $display("FAIL mid_hold_rst: got hold=%b en2=%h want 0 0", wb_hold_vld, wb_write_en2); end
    @(negedge reg_cpuclk);
    cpurst_b = 1'b1;
    #1;
    n_chk++; if (wb_hold_vld !== 1'b0 || wb_write_en2 !== '0) begin n_fail++;
      $display("FAIL mid_hold_rel: got hold=%b en2=%h want 0 0", wb_hold_vld, wb_write_en2); end
    @(negedge reg_cpuclk);
    mul_wb_vld = 1; mul_wb_rd = 4; mul_wb_data = 32'h44;
    #1;
    n_chk++; if (mul_wb_rdy !== 1'b1 || wb_write_en2 !== 32'h10 || write_data2 !== 32'h44) begin n_fail++;
      $display("FAIL mid_hold_idle: got rdy=%b en2=%h d2=%h want 1 10 44", mul_wb_rdy, wb_write_en2, write_data2); end
    idle_inputs();
  endtask

  typedef struct packed { logic [4:0] rd; logic [DW-1:0] data; } res_t;

  task automatic test_random();
    res_t               pend_q[$];
    logic               div_pend = 0, mul_pend = 0;
    logic               p2_act, x_div_rdy, x_mul_rdy, x_is_div, x_hold;
    logic [4:0]         p2_rd;
    logic [DW-1:0]      p2_data;
    for (int it = 0; it < 400; it++) begin
      @(negedge reg_cpuclk);
      ex_wb_vld  = 1'($urandom_range(0, 1)); ex_wb_rd  = 5'($urandom); ex_wb_data  = $urandom;
      lsu_wb_vld = 1'($urandom_range(0, 1)); lsu_wb_rd = 5'($urandom); lsu_wb_data = $urandom;
      if (!div_pend) begin
        div_wb_vld = 1'($urandom_range(0, 1)); div_wb_rd = 5'($urandom); div_wb_data = $urandom;
      end
      if (!mul_pend) begin
        mul_wb_vld = 1'($urandom_range(0, 1)); mul_wb_rd = 5'($urandom); mul_wb_data = $urandom;
      end
      #1;
      // A buffered MUL result always takes port 2 and blocks new handshakes.
      if (pend_q.size() > 0) begin
        p2_act = 1; p2_rd = pend_q[0].rd; p2_data = pend_q[0].data; x_is_div = 0;
        x_div_rdy = 0; x_mul_rdy = 0; x_hold = 1;
      end else begin
        x_hold = 0; x_div_rdy = div_wb_vld; x_mul_rdy = mul_wb_vld;
        p2_act = div_wb_vld | mul_wb_vld; x_is_div = div_wb_vld;
        p2_rd   = div_wb_vld ? div_wb_rd   : mul_wb_rd;
        p2_data = div_wb_vld ? div_wb_data : mul_wb_data;
      end
      n_chk++; if (wb_write_en0 !== onehot(ex_wb_vld, ex_wb_rd) || write_data0 !== ex_wb_data) begin n_fail++;
        $display("FAIL rnd_p0 it=%0d: got %h/%h want %h/%h", it, wb_write_en0, write_data0, onehot(ex_wb_vld, ex_wb_rd), ex_wb_data); end
      n_chk++; if (wb_write_en1 !== onehot(lsu_wb_vld, lsu_wb_rd) || write_data1 !== lsu_wb_data) begin n_fail++;
        $display("FAIL rnd_p1 it=%0d: got %h/%h want %h/%h", it, wb_write_en1, write_data1, onehot(lsu_wb_vld, lsu_wb_rd), lsu_wb_data); end
      n_chk++; if (wb_write_en2 !== onehot(p2_act, p2_rd)) begin n_fail++;
        $display("FAIL rnd_en2 it=%0d: got %h want %h", it, wb_write_en2, onehot(p2_act, p2_rd)); end
      if (p2_act) begin
        n_chk++; if (write_data2 !== p2_data) begin n_fail++;
          $display("FAIL rnd_d2 it=%0d: got %h want %h", it, write_data2, p2_data); end
      end
      n_chk++; if ({div_wb_rdy, mul_wb_rdy, wb_p2_is_div, wb_hold_vld} !== {x_div_rdy, x_mul_rdy, x_is_div, x_hold}) begin n_fail++;
        $display("FAIL rnd_ctl it=%0d: got rdy=%b%b is_div=%b hold=%b want %b%b %b %b", it,
                 div_wb_rdy, mul_wb_rdy, wb_p2_is_div, wb_hold_vld, x_div_rdy, x_mul_rdy, x_is_div, x_hold); end
      if (pend_q.size() > 0) void'(pend_q.pop_front());
      else if (div_wb_vld && mul_wb_vld) pend_q.push_back('{rd: mul_wb_rd, data: mul_wb_data});
      div_pend = div_wb_vld && !x_div_rdy;
      mul_pend = mul_wb_vld && !x_mul_rdy;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ports01();
    test_collision();
    test_x0();
    test_reset_mid_hold();
    test_random();
    @(negedge reg_cpuclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
